fw_cmd_sequencer: RTL

Command decoder and test-execution sequencer for the CMS pix28 test firmware. It accepts 32-bit command words, each made of device_id[31:28], op_code[27:24] and body[23:0]. It holds the static and execute configuration registers and maintains the 32-bit firmware status word. It also launches exactly one test engine (test1..test4) per OP_CODE_W_EXECUTE and tracks that test until it completes. It sits between the AXI command path and the IP1/IP2 test state machines.

---
 rtl/fw_cmd_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/fw_cmd_sequencer.sv
// Command decoder and test-execution sequencer for the CMS pix28 test firmware.
// Decodes {device_id, op_code, body} command words, holds the static/execute
// configuration, maintains the firmware status word and launches one test engine
// per execute command, tracking it until its done pulse returns.
// Optional feature: define CMS_PIX28_EXEC_TIMEOUT_EN to enable the RUN watchdog.
module fw_cmd_sequencer #(
    parameter logic [3:0]  DEVICE_ID       = 4'h1,
    parameter int unsigned TEST_NUM_LSB    = 12,
    parameter logic [3:0]  SUPPORTED_TESTS = 4'hF,
    parameter int unsigned RST_CYCLES      = 8,
    parameter logic [23:0] TIMEOUT_CYCLES  = 24'hFFFFFF
) (
    input  logic        fw_axi_clk,
    input  logic        fw_rst,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    output logic [23:0] cfg_static_0,
    output logic [23:0] cfg_static_1,
    output logic [23:0] cfg_execute,
    output logic        array_req,
    output logic [3:0]  array_op,
    output logic [23:0] array_body,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [3:0]  test_start,
    output logic        test_abort,
    input  logic [3:0]  test_done,
    output logic        busy,
    output logic [31:0] status,
    output logic        fw_soft_rst
);

    localparam logic [3:0] OP_NOOP             = 4'h0;
    localparam logic [3:0] OP_W_RST_FW         = 4'h1;
    localparam logic [3:0] OP_W_CFG_STATIC_0   = 4'h2;
    localparam logic [3:0] OP_R_CFG_STATIC_0   = 4'h3;
    localparam logic [3:0] OP_W_CFG_STATIC_1   = 4'h4;
    localparam logic [3:0] OP_R_CFG_STATIC_1   = 4'h5;
    localparam logic [3:0] OP_W_STATUS_FW_CLEAR = 4'hE;
    localparam logic [3:0] OP_W_EXECUTE        = 4'hF;

    localparam int unsigned StatusExecIdx  = 13;
    localparam int unsigned StatusDoneBase = 14;
    localparam int unsigned StatusErrIdx   = 31;

    localparam int unsigned SoftW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    // Elaboration-time sanity of the configuration.
    if (RST_CYCLES < 1 || TIMEOUT_CYCLES == 24'd0) begin : g_param_check
        $error("fw_cmd_sequencer: RST_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StLaunch, StRun} state_t;

    state_t           state;
    logic [3:0]       test_sel;
    logic [SoftW-1:0] soft_cnt;
`ifdef CMS_PIX28_EXEC_TIMEOUT_EN
    logic [23:0]      run_cnt;
    logic             timeout_hit;
`endif

    logic [3:0]  op;
    logic [23:0] body;
    logic        cmd_acc;
    logic        is_rst;
    logic [3:0]  exec_t;
    logic        exec_ok;
    logic        exec_launch;
    logic        done_hit;
    logic        status_clr;
    logic [31:0] status_set;
    logic [31:0] status_next;

    // Position of the single set bit of a one-hot test selector.
    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        if (oh[3])      return 2'd3;
        else if (oh[2]) return 2'd2;
        else if (oh[1]) return 2'd1;
        else            return 2'd0;
    endfunction

    // Command decode, launch qualification and next status word.
    always_comb begin
        op     = cmd_data[27:24];
        body   = cmd_data[23:0];
        exec_t = cmd_data[TEST_NUM_LSB +: 4];
        // During soft reset only a further W_RST_FW is honoured.
        cmd_acc = cmd_valid && (cmd_data[31:28] == DEVICE_ID) &&
                  (!fw_soft_rst || op == OP_W_RST_FW);
        is_rst  = cmd_acc && (op == OP_W_RST_FW);
        exec_ok = (exec_t != 4'd0) && ((exec_t & (exec_t - 4'd1)) == 4'd0) &&
                  ((exec_t & SUPPORTED_TESTS) != 4'd0) && !busy;
        exec_launch = cmd_acc && (op == OP_W_EXECUTE) && exec_ok;
        done_hit    = (state == StRun) && ((test_done & test_sel) != 4'd0);
`ifdef CMS_PIX28_EXEC_TIMEOUT_EN
        timeout_hit = (state == StRun) && !done_hit && (run_cnt == TIMEOUT_CYCLES - 24'd1);
`endif

        status_set = '0;
        status_clr = 1'b0;
        if (cmd_acc) begin
            case (op)
                OP_NOOP: ;
                OP_W_RST_FW: begin
                    status_clr    = 1'b1;
                    status_set[0] = 1'b1;
                end
                // The clear leaves no trace of its own.
                OP_W_STATUS_FW_CLEAR: status_clr = 1'b1;
                OP_W_EXECUTE: begin
                    status_set[StatusExecIdx] = 1'b1;
                    if (!exec_ok) status_set[StatusErrIdx] = 1'b1;
                end
                default: status_set = 32'd1 << (op - 4'd1);
            endcase
        end
        // An abort via W_RST_FW wins over a same-cycle completion.
        if (done_hit && !is_rst) begin
            status_set[StatusDoneBase + int'(onehot_idx(test_sel))] = 1'b1;
        end
`ifdef CMS_PIX28_EXEC_TIMEOUT_EN
        if (timeout_hit && !is_rst) status_set[StatusErrIdx] = 1'b1;
`endif
        status_next = (status_clr ? 32'd0 : status) | status_set;
    end

    // Configuration registers, pulses, soft reset counter and test FSM.
    always_ff @(posedge fw_axi_clk) begin
        if (fw_rst) begin
            cfg_static_0 <= '0;
            cfg_static_1 <= '0;
            cfg_execute  <= '0;
            array_req    <= 1'b0;
            array_op     <= '0;
            array_body   <= '0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            test_start   <= '0;
            test_abort   <= 1'b0;
            busy         <= 1'b0;
            status       <= '0;
            fw_soft_rst  <= 1'b0;
            soft_cnt     <= '0;
            test_sel     <= '0;
            state        <= StIdle;
`ifdef CMS_PIX28_EXEC_TIMEOUT_EN
            run_cnt      <= '0;
`endif
        end else begin
            rd_valid   <= 1'b0;
            array_req  <= 1'b0;
            test_start <= '0;
            test_abort <= 1'b0;
            status     <= status_next;

            if (cmd_acc) begin
                case (op)
                    OP_W_RST_FW: begin
                        cfg_static_0 <= '0;
                        cfg_static_1 <= '0;
                        cfg_execute  <= '0;
                    end
                    OP_W_CFG_STATIC_0: if (!busy) cfg_static_0 <= body;
                    OP_W_CFG_STATIC_1: if (!busy) cfg_static_1 <= body;
                    OP_R_CFG_STATIC_0: begin
                        rd_valid <= 1'b1;
                        rd_data  <= {8'h00, cfg_static_0};
                    end
                    OP_R_CFG_STATIC_1: begin
                        rd_valid <= 1'b1;
                        rd_data  <= {8'h00, cfg_static_1};
                    end
                    OP_W_EXECUTE: cfg_execute <= body;
                    OP_NOOP, OP_W_STATUS_FW_CLEAR: ;
                    default: begin
                        array_req  <= 1'b1;
                        array_op   <= op;
                        array_body <= body;
                    end
                endcase
            end

            if (is_rst) begin
                fw_soft_rst <= 1'b1;
                soft_cnt    <= SoftW'(RST_CYCLES - 1);
            end else if (soft_cnt != '0) begin
                soft_cnt <= soft_cnt - SoftW'(1);
            end else begin
                fw_soft_rst <= 1'b0;
            end

            if (is_rst) begin
                test_abort <= busy;
                busy       <= 1'b0;
                state      <= StIdle;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (exec_launch) begin
                            test_start <= exec_t;
                            test_sel   <= exec_t;
                            busy       <= 1'b1;
                            state      <= StLaunch;
                        end
                    end
                    StLaunch: begin
`ifdef CMS_PIX28_EXEC_TIMEOUT_EN
                        run_cnt <= '0;
`endif
                        state <= StRun;
                    end
                    StRun: begin
                        if (done_hit) begin
                            busy  <= 1'b0;
                            state <= StIdle;
`ifdef CMS_PIX28_EXEC_TIMEOUT_EN
                        end else if (timeout_hit) begin
                            test_abort <= 1'b1;
                            busy       <= 1'b0;
                            state      <= StIdle;
                        end else begin
                            run_cnt <= run_cnt + 24'd1;
`endif
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
